keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end for the elevator panel. It drives the columns of a 4x4 keypad, samples and debounces the rows, and turns each accepted press into a 4-bit code and a one-cycle strobe. It sits directly upstream of the login/command FSM, which consumes `key_code` as its BCD input: 0-9 for digits, 11 for `*`, 12 for `#`, 13 for `*#`.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays driven. Minimum 4.
- `DEBOUNCE_SCANS`, default 8: number of consecutive identical full-scan snapshots that count as stable. Minimum 2.
- `CLK`  in  1  single system clock; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `CLK`.
- `col_out`  out  4  column drive, active-low, exactly one bit low at any time.
- `key_code`  out  4  last emitted code; holds its value between strobes.
- `key_valid`  out  1  one-cycle strobe; `key_code` is valid in that same cycle.
- `key_held`  out  1  high while the FSM is in LOCKED (an accepted key is not yet released).

## Operation
- **Keymap** (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Digits map to their value, `*` to 11, `#` to 12. A-D are invalid.
- **Row synchronizer:** `row_in` passes through a 2-flop synchronizer.
- **Scan:**
  - A slot counter counts 0..`SCAN_DIV`-1.
  - A 2-bit column index advances 0,1,2,3,0... when the slot wraps.
  - `col_out` = ~(1<<index).
  - The synchronized rows are sampled into the 16-bit snapshot on the last cycle of each slot.
  - A snapshot completes on the last cycle of column 3.
- **Debounce:**
  - At each completed snapshot, compare it with the previous one.
  - If equal, increment the stable counter, saturating at `DEBOUNCE_SCANS`. If different, set it to 1.
  - "Stable" is the event of the counter reaching `DEBOUNCE_SCANS`. It fires once per settled pattern.
- **Classification** of a stable snapshot:
  - Empty: RELEASE.
  - Exactly one valid key: that key's code.
  - Exactly {`*`,`#`}: 13.
  - Anything else (A-D, any other multi-key pattern, ghosting): INVALID.
- **FSM states:** IDLE, LOCKED.
  - IDLE, stable with a code: emit the code, go to LOCKED.
  - IDLE, stable with INVALID: go to LOCKED, no emit. This blocks repeats until release.
  - IDLE, stable with RELEASE: stay in IDLE.
  - LOCKED, stable with RELEASE: go to IDLE.
  - LOCKED, stable with 13 when the last emitted code is 11 or 12: emit 13 once, stay in LOCKED. This is the upgrade path for `*` then `#` held together.
  - LOCKED, any other stable pattern: ignored.
- **No auto-repeat.** A held key emits exactly once.

## Timing
- **Reset values:**
  - `col_out`=4'b1110
  - `key_code`=4'hF
  - `key_valid`=0
  - `key_held`=0
  - FSM=IDLE
  - Counters, synchronizer and snapshots: 0/released
- **Reset mid-operation:** all state clears asynchronously and any pending emission is dropped. After `RST` deasserts, scanning restarts at column 0, slot 0.
- **Scan period:** one full scan is 4*`SCAN_DIV` cycles. Synchronizer latency is 2 cycles. Because sampling happens at the end of the slot, `SCAN_DIV`≥4 guarantees the sampled rows belong to the column currently driven.
- **Emission latency:**
  - `key_valid` rises the cycle after the stable-event snapshot completes.
  - A press that is clean from the start of a scan emits after `DEBOUNCE_SCANS` full scans plus 1 cycle.
  - `key_code` updates in the same cycle `key_valid` rises and holds afterwards.
- **`key_held` timing:** rises together with the LOCKED entry. It falls the cycle after the release becomes stable.
- **Simultaneous events:**
  - A snapshot change in the same cycle as a would-be stable event resets the counter; no emission.
  - At most one strobe per snapshot.
- **Downstream contract:** the consumer must sample only on `key_valid`. Code 15 is never strobed.

## Test plan
Parameters for all scenarios: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3.
- **Single digit:** hold r1c1 ("5") from reset.
  - `key_valid` pulses exactly once with `key_code`=5.
  - `key_held`=1 until the key is released and 3 empty scans have passed, then 0.
- **Bounce:** toggle r3c1 ("0") every 10 cycles for 100 cycles, then hold it.
  - No strobe during bouncing.
  - Exactly one strobe with code 0, after 3 stable scans.
- **Star-hash:**
  - Press `*` and `#` in the same cycle: a single strobe with code 13.
  - Press `*`, wait until code 11 is emitted, then add `#`: a second strobe with code 13, and no further strobes while both are held.
- **Invalid / ghost:**
  - Hold "A": no strobe and `key_held`=1.
  - Hold "1"+"2": no strobe.
  - After release, pressing "7" yields code 7.
- **Sequence:** enter `*`,1,2,0 with releases in between. The strobes carry codes 11,1,2,0 in order, and `key_code` holds 0 afterwards.
- **Reset mid-press:** assert `RST` while "9" is held with the debounce count at 2.
  - Outputs return to their reset values.
  - After deassertion, with "9" still held: one strobe with code 9 after 3 new scans.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: column scan, row synchronizer, full-scan debounce,
// key classification and a one-shot press FSM feeding the command logic.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(DEBOUNCE_SCANS - 1);

    localparam logic [1:0] CLS_RELEASE = 2'd0;
    localparam logic [1:0] CLS_CODE    = 2'd1;
    localparam logic [1:0] CLS_INVALID = 2'd2;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    // Snapshot bit r*4+c is 1 when the key at row r, column c is pressed.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd12:   code = 4'd11;
            4'd13:   code = 4'd0;
            4'd14:   code = 4'd12;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    // Returns {class, code}; code is only meaningful for CLS_CODE.
    function automatic logic [5:0] classify(input logic [15:0] snap);
        logic [4:0] ones;
        logic [3:0] idx;
        logic [5:0] res;
        ones = 5'd0;
        idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end else begin
                ones = ones;
            end
        end
        if (ones == 5'd0) begin
            res = {CLS_RELEASE, 4'hF};
        end else if (snap == 16'h5000) begin
            res = {CLS_CODE, 4'd13};
        end else if (ones == 5'd1 && key_map(idx) != 4'hF) begin
            res = {CLS_CODE, key_map(idx)};
        end else begin
            res = {CLS_INVALID, 4'hF};
        end
        return res;
    endfunction

    logic [3:0]        row_meta_r, row_sync_r;
    logic [SLOT_W-1:0] slot_r;
    logic [1:0]        col_idx_r;
    logic [3:0]        col_out_r;
    logic [15:0]       snap_work_r, snap_prev_r;
    logic [CNT_W-1:0]  stab_cnt_r;
    state_t            state_r;
    logic [3:0]        key_code_r;
    logic              key_valid_r, key_held_r;

    logic [3:0]  row_press_s;
    logic [15:0] snap_next_s;
    logic        slot_last_s, snap_done_s, snap_same_s, stable_s;
    logic [1:0]  cls_s;
    logic [3:0]  code_s;

    assign row_press_s = ~row_sync_r;
    assign slot_last_s = (slot_r == SLOT_LAST);
    assign snap_done_s = slot_last_s && (col_idx_r == 2'd3);
    assign snap_same_s = (snap_next_s == snap_prev_r);
    assign stable_s    = snap_done_s && snap_same_s && (stab_cnt_r == CNT_PRE);
    assign {cls_s, code_s} = classify(snap_next_s);

    // Working snapshot with the currently driven column replaced by the live rows.
    always_comb begin
        snap_next_s = snap_work_r;
        case (col_idx_r)
            2'd0:    {snap_next_s[12], snap_next_s[8], snap_next_s[4], snap_next_s[0]} = row_press_s;
            2'd1:    {snap_next_s[13], snap_next_s[9], snap_next_s[5], snap_next_s[1]} = row_press_s;
            2'd2:    {snap_next_s[14], snap_next_s[10], snap_next_s[6], snap_next_s[2]} = row_press_s;
            2'd3:    {snap_next_s[15], snap_next_s[11], snap_next_s[7], snap_next_s[3]} = row_press_s;
            default: snap_next_s = snap_work_r;
        endcase
    end

    // Row synchronizer, column scan and snapshot debounce.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            row_meta_r  <= 4'hF;
            row_sync_r  <= 4'hF;
            slot_r      <= '0;
            col_idx_r   <= 2'd0;
            col_out_r   <= 4'b1110;
            snap_work_r <= 16'h0000;
            snap_prev_r <= 16'h0000;
            stab_cnt_r  <= '0;
        end else begin
            row_meta_r <= row_in;
            row_sync_r <= row_meta_r;
            if (slot_last_s) begin
                slot_r      <= '0;
                col_idx_r   <= col_idx_r + 2'd1;
                col_out_r   <= {col_out_r[2:0], col_out_r[3]};
                snap_work_r <= snap_next_s;
            end else begin
                slot_r <= slot_r + SLOT_W'(1);
            end
            if (snap_done_s) begin
                snap_prev_r <= snap_next_s;
                if (!snap_same_s) begin
                    stab_cnt_r <= CNT_W'(1);
                end else if (stab_cnt_r != CNT_MAX) begin
                    stab_cnt_r <= stab_cnt_r + CNT_W'(1);
                end else begin
                    stab_cnt_r <= stab_cnt_r;
                end
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    // Press FSM: one strobe per accepted press, plus the one-time star/hash upgrade.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            key_code_r  <= 4'hF;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            if (stable_s) begin
                case (state_r)
                    ST_IDLE: begin
                        case (cls_s)
                            CLS_CODE: begin
                                key_code_r  <= code_s;
                                key_valid_r <= 1'b1;
                                state_r     <= ST_LOCKED;
                                key_held_r  <= 1'b1;
                            end
                            CLS_INVALID: begin
                                state_r    <= ST_LOCKED;
                                key_held_r <= 1'b1;
                            end
                            default: begin
                                state_r    <= ST_IDLE;
                                key_held_r <= 1'b0;
                            end
                        endcase
                    end
                    ST_LOCKED: begin
                        if (cls_s == CLS_RELEASE) begin
                            state_r    <= ST_IDLE;
                            key_held_r <= 1'b0;
                        end else if (cls_s == CLS_CODE && code_s == 4'd13 &&
                                     (key_code_r == 4'd11 || key_code_r == 4'd12)) begin
                            key_code_r  <= 4'd13;
                            key_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_LOCKED;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        key_held_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign col_out   = col_out_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, strobe scoreboard,
// table-driven press/release vectors and hand-written timing sequences.
module tb_keypad_scanner;

    localparam int SD   = 4;
    localparam int DS   = 3;
    localparam int SCAN = 4 * SD;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];
    logic [3:0] last_code;

    typedef struct {
        string      name;
        logic [15:0] keys;
        logic        strobe;
        logic [3:0]  code;
    } vec_t;

    vec_t vecs[11];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .CLK(CLK), .RST(RST), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 CLK = ~CLK;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    // Strobe scoreboard.
    always @(negedge CLK) begin
        if (key_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: got code %0d, required no strobe", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    n_err++;
                    $display("FAIL strobe_code: got %0d, required %0d", key_code, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d strobes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge CLK);
    endtask

    task automatic reset_dut(input logic [15:0] k);
        @(negedge CLK);
        RST  = 1'b0;
        keys = k;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
    endtask

    // Strobe must appear exactly DS full scans (+1 cycle) after reset release.
    task automatic check_latency(input string name, input logic [3:0] code);
        repeat (DS * SCAN - 1) @(posedge CLK);
        @(negedge CLK);
        check({name, "_early"}, key_valid, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        check({name, "_valid"}, key_valid, 1'b1);
        check({name, "_code"}, key_code, code);
    endtask

    initial begin
        vecs[0]  = '{"v_5",       16'h0020, 1'b1, 4'd5};
        vecs[1]  = '{"v_0",       16'h2000, 1'b1, 4'd0};
        vecs[2]  = '{"v_star",    16'h1000, 1'b1, 4'd11};
        vecs[3]  = '{"v_hash",    16'h4000, 1'b1, 4'd12};
        vecs[4]  = '{"v_starhash",16'h5000, 1'b1, 4'd13};
        vecs[5]  = '{"v_A",       16'h0008, 1'b0, 4'hF};
        vecs[6]  = '{"v_D",       16'h8000, 1'b0, 4'hF};
        vecs[7]  = '{"v_1_2",     16'h0003, 1'b0, 4'hF};
        vecs[8]  = '{"v_7",       16'h0100, 1'b1, 4'd7};
        vecs[9]  = '{"v_ghost",   16'h0013, 1'b0, 4'hF};
        vecs[10] = '{"v_3",       16'h0004, 1'b1, 4'd3};

        // Reset values.
        repeat (2) @(negedge CLK);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_code", key_code, 4'hF);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);

        // Single digit held from reset.
        reset_dut(16'h0020);
        exp_q.push_back(4'd5);
        check_latency("digit5", 4'd5);
        wait_scans(5);
        check_q("digit5_q");
        check("digit5_held", key_held, 1'b1);
        keys = 16'h0000;
        wait_scans(2);
        check("digit5_held_rel2", key_held, 1'b1);
        wait_scans(4);
        check("digit5_held_rel", key_held, 1'b0);
        check_q("digit5_norepeat");
        last_code = 4'd5;

        // Table-driven press/release vectors.
        for (int i = 0; i < 11; i++) begin
            keys = vecs[i].keys;
            if (vecs[i].strobe) begin
                exp_q.push_back(vecs[i].code);
                last_code = vecs[i].code;
            end
            wait_scans(6);
            check_q({vecs[i].name, "_q"});
            check({vecs[i].name, "_held"}, key_held, 1'b1);
            keys = 16'h0000;
            wait_scans(6);
            check({vecs[i].name, "_rel_held"}, key_held, 1'b0);
            check({vecs[i].name, "_hold_code"}, key_code, last_code);
            check_q({vecs[i].name, "_rel_q"});
        end

        // Star first, then hash added: upgrade to 13 exactly once.
        keys = 16'h1000;
        exp_q.push_back(4'd11);
        wait_scans(6);
        check_q("upg_star");
        keys = 16'h5000;
        exp_q.push_back(4'd13);
        wait_scans(6);
        check_q("upg_13");
        wait_scans(6);
        check_q("upg_once");
        check("upg_code", key_code, 4'd13);
        check("upg_held", key_held, 1'b1);
        keys = 16'h0000;
        wait_scans(6);
        check("upg_rel_held", key_held, 1'b0);

        // Bounce on "0" every 10 cycles for 100 cycles, then steady.
        reset_dut(16'h2000);
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h2000 : 16'h0000;
            repeat (10) @(negedge CLK);
        end
        keys = 16'h2000;
        exp_q.push_back(4'd0);
        wait_scans(8);
        check_q("bounce_q");
        check("bounce_code", key_code, 4'd0);
        keys = 16'h0000;
        wait_scans(6);

        // Sequence *,1,2,0 with releases.
        for (int i = 0; i < 4; i++) begin
            logic [15:0] seq_k[4];
            logic [3:0]  seq_c[4];
            seq_k = '{16'h1000, 16'h0001, 16'h0002, 16'h2000};
            seq_c = '{4'd11, 4'd1, 4'd2, 4'd0};
            keys = seq_k[i];
            exp_q.push_back(seq_c[i]);
            wait_scans(6);
            keys = 16'h0000;
            wait_scans(6);
        end
        check_q("seq_q");
        check("seq_hold_code", key_code, 4'd0);

        // Reset while "9" is held with the debounce count at 2.
        reset_dut(16'h0400);
        repeat (2 * SCAN + 8) @(posedge CLK);
        @(negedge CLK);
        check_q("midrst_pre_q");
        RST = 1'b0;
        #1;
        check("midrst_col_out", col_out, 4'b1110);
        check("midrst_key_code", key_code, 4'hF);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_key_held", key_held, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        exp_q.push_back(4'd9);
        check_latency("midrst9", 4'd9);
        keys = 16'h0000;
        wait_scans(6);
        check_q("midrst_q");
        check("midrst_rel_held", key_held, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
